// File: rtl/benes_cfg_ctrl_if.sv
// -----------------------------------------------------------------------------
// benes_cfg_ctrl_if
// Handshake bundle for the Benes outer-stage sequencing controller.
//   Request side  : req_valid / req_ready / req_perm (24-bit, 3 bits per input)
//   Result side   : cfg_valid / cfg_ready / cfg_ci / cfg_co / cfg_err
// Modports:
//   master : permutation source and result sink (drives req_*, cfg_ready)
//   slave  : the controller (drives req_ready and cfg_* results)
// -----------------------------------------------------------------------------
interface benes_cfg_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [23:0] req_perm;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [7:0]  cfg_ci;
   logic [7:0]  cfg_co;
   logic        cfg_err;

   modport master (
      output req_valid, req_perm, cfg_ready,
      input  req_ready, cfg_valid, cfg_ci, cfg_co, cfg_err
   );

   modport slave (
      input  req_valid, req_perm, cfg_ready,
      output req_ready, cfg_valid, cfg_ci, cfg_co, cfg_err
   );
endinterface

// File: rtl/benes_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// benes_cfg_ctrl
// Sequencing controller for the 8-port Benes outer-stage coloring unit.
// Accepts a destination permutation, derives the inverse (mn) and neighbour
// (nb) tables, pulses the coloring unit's start, waits COLOR_LAT cycles,
// captures the ci/co color tables and offers them downstream.
//
// Optional feature macro: BENES_CFG_CHECK_EN
//   defined   : non-bijective requests are flagged in LOAD and take the
//               error path (cfg_err = 1, no start pulse).
//   undefined : no check logic, cfg_err stays 0, every request is launched.
//
// Ports:
//   clk        in   clock, rising edge
//   areset_n   in   asynchronous active-low reset
//   bus        if   slave side of benes_cfg_ctrl_if (req_* / cfg_* handshakes)
//   col_start  out  one-cycle start pulse to the coloring unit
//   col_mp     out  registered permutation, slice i -> mp_i
//   col_mn     out  inverse permutation, mn[mp[i]] = i
//   col_nb     out  neighbour table, nb[i] = mn[mp[i] ^ 1]
//   col_ci     in   coloring unit input-switch colors
//   col_co     in   coloring unit output-switch colors
//   busy       out  high in every state except IDLE
// -----------------------------------------------------------------------------
module benes_cfg_ctrl #(
   parameter int unsigned COLOR_LAT = 6    // WAIT cycles, legal 6..15
) (
   input  logic                  clk,
   input  logic                  areset_n,
   benes_cfg_ctrl_if.slave       bus,
   output logic                  col_start,
   output logic [23:0]           col_mp,
   output logic [23:0]           col_mn,
   output logic [23:0]           col_nb,
   input  logic [7:0]            col_ci,
   input  logic [7:0]            col_co,
   output logic                  busy
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_LAUNCH,
      ST_WAIT,
      ST_DONE
   } state_t;

   localparam logic [3:0] WAIT_LAST = 4'(COLOR_LAT - 1);

   state_t      state_reg;
   logic [3:0]  wait_cnt_reg;
   logic [23:0] mp_reg;
   logic [23:0] mn_reg;
   logic [23:0] nb_reg;
   logic        start_reg;
   logic        ready_reg;
   logic        valid_reg;
   logic [7:0]  ci_reg;
   logic [7:0]  co_reg;
   logic        err_reg;

   // Table derivation from the registered permutation
   logic [2:0]  mp_arr [8];
   logic [2:0]  mn_arr [8];
   logic [2:0]  nb_arr [8];
   logic [7:0]  hit;          // hit[v]: some input maps to output v
   logic [23:0] mn_next;
   logic [23:0] nb_next;
   logic        perm_err;

   genvar gi, gj;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_unpack
         assign mp_arr[gi] = mp_reg[3*gi +: 3];
      end

      // For each output value gi, find the input(s) that target it. For a
      // bijection exactly one eq bit is set, so OR-ing the indices yields mn.
      for (gi = 0; gi < 8; gi++) begin : g_inv
         logic [7:0] eq;
         logic [2:0] mn_slice;
         for (gj = 0; gj < 8; gj++) begin : g_eq
            assign eq[gj] = (mp_arr[gj] == 3'(gi));
         end
         always_comb begin
            mn_slice = 3'd0;
            for (int i = 0; i < 8; i++) begin
               if (eq[i]) begin
                  mn_slice = mn_slice | 3'(i);
               end
            end
         end
         assign hit[gi]    = |eq;
         assign mn_arr[gi] = mn_slice;
      end

      for (gi = 0; gi < 8; gi++) begin : g_nb
         assign nb_arr[gi]             = mn_arr[mp_arr[gi] ^ 3'd1];
         assign mn_next[3*gi +: 3]     = mn_arr[gi];
         assign nb_next[3*gi +: 3]     = nb_arr[gi];
      end
   endgenerate

`ifdef BENES_CFG_CHECK_EN
   // Eight slices cover all eight outputs exactly when no two are equal.
   assign perm_err = ~&hit;
`else
   assign perm_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         state_reg    <= ST_IDLE;
         wait_cnt_reg <= 4'd0;
         mp_reg       <= 24'd0;
         mn_reg       <= 24'd0;
         nb_reg       <= 24'd0;
         start_reg    <= 1'b0;
         ready_reg    <= 1'b1;   // IDLE after reset, so a request may be taken
         valid_reg    <= 1'b0;
         ci_reg       <= 8'd0;
         co_reg       <= 8'd0;
         err_reg      <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  mp_reg    <= bus.req_perm;
                  ready_reg <= 1'b0;
                  state_reg <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               mn_reg <= mn_next;
               nb_reg <= nb_next;
               if (perm_err) begin
                  ci_reg    <= 8'd0;
                  co_reg    <= 8'd0;
                  err_reg   <= 1'b1;
                  valid_reg <= 1'b1;
                  state_reg <= ST_DONE;
               end else begin
                  start_reg <= 1'b1;
                  state_reg <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               start_reg    <= 1'b0;
               wait_cnt_reg <= 4'd0;
               state_reg    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (wait_cnt_reg == WAIT_LAST) begin
                  ci_reg    <= col_ci;
                  co_reg    <= col_co;
                  err_reg   <= 1'b0;
                  valid_reg <= 1'b1;
                  state_reg <= ST_DONE;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 4'd1;
               end
            end
            ST_DONE: begin
               if (bus.cfg_ready) begin
                  valid_reg <= 1'b0;
                  ready_reg <= 1'b1;
                  state_reg <= ST_IDLE;
               end
            end
            default: begin
               start_reg <= 1'b0;
               valid_reg <= 1'b0;
               ready_reg <= 1'b1;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready = ready_reg;
   assign bus.cfg_valid = valid_reg;
   assign bus.cfg_ci    = ci_reg;
   assign bus.cfg_co    = co_reg;
   assign bus.cfg_err   = err_reg;
   assign busy          = ~ready_reg;
   assign col_start     = start_reg;
   assign col_mp        = mp_reg;
   assign col_mn        = mn_reg;
   assign col_nb        = nb_reg;

endmodule

// File: tb/tb_benes_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_benes_cfg_ctrl
// Self-checking bench for benes_cfg_ctrl. A transaction-level model predicts
// every output per cycle from the accept cycle of the current request
// (LOAD = accept+1, start = accept+2, capture at end of accept+2+COLOR_LAT,
// result from accept+3+COLOR_LAT, or accept+2 on the error path).
// Honors BENES_CFG_CHECK_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_benes_cfg_ctrl;
   localparam int L = 6;
`ifdef BENES_CFG_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        areset_n;
   logic        col_start;
   logic [23:0] col_mp, col_mn, col_nb;
   logic [7:0]  col_ci, col_co;
   logic        busy;

   always #5 clk = ~clk;

   benes_cfg_ctrl_if bus ();

   benes_cfg_ctrl #(.COLOR_LAT(L)) dut (
      .clk       (clk),
      .areset_n  (areset_n),
      .bus       (bus.slave),
      .col_start (col_start),
      .col_mp    (col_mp),
      .col_mn    (col_mn),
      .col_nb    (col_nb),
      .col_ci    (col_ci),
      .col_co    (col_co),
      .busy      (busy)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;

   // Model state
   bit          m_busy, m_err, m_known, m_cerr;
   int          m_acc, m_done, txn_cnt;
   logic [23:0] m_mp, m_mn, m_nb;
   logic [7:0]  m_ci, m_co;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [23:0] inv_of(input logic [23:0] p);
      logic [23:0] r = 24'd0;
      for (int i = 0; i < 8; i++) begin
         int v = int'(p[3*i +: 3]);
         r[3*v +: 3] = 3'(i);
      end
      return r;
   endfunction

   function automatic logic [23:0] nb_of(input logic [23:0] p);
      logic [23:0] inv = inv_of(p);
      logic [23:0] r   = 24'd0;
      for (int i = 0; i < 8; i++) begin
         int j = int'(p[3*i +: 3]) ^ 1;
         r[3*i +: 3] = inv[3*j +: 3];
      end
      return r;
   endfunction

   function automatic bit is_bij(input logic [23:0] p);
      bit [7:0] seen = 8'd0;
      for (int i = 0; i < 8; i++) seen[int'(p[3*i +: 3])] = 1'b1;
      return &seen;
   endfunction

   function automatic logic [23:0] rand_perm();
      int a [8];
      logic [23:0] r = 24'd0;
      for (int i = 0; i < 8; i++) a[i] = i;
      for (int i = 7; i > 0; i--) begin
         int j = int'($urandom_range(i, 0));
         int t = a[i];
         a[i] = a[j];
         a[j] = t;
      end
      for (int i = 0; i < 8; i++) r[3*i +: 3] = 3'(a[i]);
      return r;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_err = 0; m_known = 1; m_cerr = 0;
      m_mp = '0; m_mn = '0; m_nb = '0; m_ci = '0; m_co = '0;
   endtask

   // Called right after each rising edge; cyc is the cycle that edge ended.
   task automatic model_update();
      if (!areset_n) return;
      if (m_busy) begin
         if (cyc == m_acc + 1) begin
            m_mn    = inv_of(m_mp);
            m_nb    = nb_of(m_mp);
            m_known = is_bij(m_mp);
            if (m_err) begin
               m_ci = '0; m_co = '0; m_cerr = 1;
            end
         end
         if (!m_err && cyc == m_acc + 2 + L) begin
            m_ci = col_ci; m_co = col_co; m_cerr = 0;
         end
         if (cyc >= m_done && bus.cfg_ready) begin
            m_busy = 0;
            txn_cnt++;
            $display("TXN %0d perm=%06h err=%0d ci=%02h co=%02h accept=%0d done=%0d",
                     txn_cnt, m_mp, m_cerr, m_ci, m_co, m_acc, m_done);
         end
      end else if (bus.req_valid) begin
         m_busy = 1;
         m_acc  = cyc;
         m_mp   = bus.req_perm;
         m_err  = CHECK_EN && !is_bij(bus.req_perm);
         m_done = m_acc + (m_err ? 2 : 3 + L);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      cyc++;
      @(negedge clk);
      col_ci = 8'($urandom);
      col_co = 8'($urandom);
   endtask

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_ready", 32'(bus.req_ready), 32'(!m_busy));
         chk("busy",      32'(busy),          32'(m_busy));
         chk("col_start", 32'(col_start),     32'(m_busy && !m_err && cyc == m_acc + 2));
         chk("cfg_valid", 32'(bus.cfg_valid), 32'(m_busy && cyc >= m_done));
         chk("cfg_ci",    32'(bus.cfg_ci),    32'(m_ci));
         chk("cfg_co",    32'(bus.cfg_co),    32'(m_co));
         chk("cfg_err",   32'(bus.cfg_err),   32'(m_cerr));
         chk("col_mp",    32'(col_mp),        32'(m_mp));
         if (m_known) begin
            chk("col_mn", 32'(col_mn), 32'(m_mn));
            chk("col_nb", 32'(col_nb), 32'(m_nb));
         end
      end
   end

   task automatic run_txn(input logic [23:0] p, input int ready_delay, input bit inject,
                          output int start_c, output int valid_c,
                          output logic [7:0] ci_s, output logic [7:0] co_s);
      int acc;
      int w = 0;
      bit done = 0;
      logic [7:0] v_ci = '0, v_co = '0;
      start_c = -1; valid_c = -1; ci_s = '0; co_s = '0;
      bus.req_valid = 1'b1;
      bus.req_perm  = p;
      tick();
      bus.req_valid = 1'b0;
      acc = cyc - 1;
      chk("accept_busy", 32'(busy), 32'(1));
      for (int k = 0; k < 60 && !done; k++) begin
         if (inject) begin
            // A different request during WAIT must be ignored
            bus.req_valid = (cyc >= acc + 4 && cyc <= acc + 6);
            bus.req_perm  = ~p;
            if (cyc == acc + 7) chk("ignore_mp", 32'(col_mp), 32'(p));
         end
         if (col_start === 1'b1 && start_c < 0) start_c = cyc - acc;
         if (cyc == acc + 2 + L) begin
            ci_s = col_ci; co_s = col_co;
         end
         if (bus.cfg_valid === 1'b1) begin
            if (valid_c < 0) begin
               valid_c = cyc - acc; v_ci = bus.cfg_ci; v_co = bus.cfg_co;
            end else begin
               chk("hold_ci",    32'(bus.cfg_ci),    32'(v_ci));
               chk("hold_co",    32'(bus.cfg_co),    32'(v_co));
               chk("hold_ready", 32'(bus.req_ready), 32'(0));
            end
            if (w >= ready_delay) begin
               bus.cfg_ready = 1'b1;
               tick();
               bus.cfg_ready = 1'b0;
               done = 1;
               chk("idle_after", 32'(bus.req_ready), 32'(1));
            end else begin
               w++;
               tick();
            end
         end else begin
            tick();
         end
      end
      bus.req_valid = 1'b0;
      chk("txn_done", 32'(done), 32'(1));
   endtask

   initial begin
      int s, v;
      logic [7:0] ci_s, co_s;
      logic [23:0] p;
      areset_n      = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_perm  = '0;
      bus.cfg_ready = 1'b0;
      col_ci        = '0;
      col_co        = '0;
      txn_cnt       = 0;
      model_reset();
      chk_en = 1'b1;

      // Hand-derived tables pin the model. Reversal: mn[j]=7-j and
      // nb[i] = 7-((7-i)^1) = i^1, the same neighbour table as identity.
      chk("pin_inv_id",  32'(inv_of(24'o76543210)), 32'(24'o76543210));
      chk("pin_nb_id",   32'(nb_of(24'o76543210)),  32'(24'o67452301));
      chk("pin_inv_rev", 32'(inv_of(24'o01234567)), 32'(24'o01234567));
      chk("pin_nb_rev",  32'(nb_of(24'o01234567)),  32'(24'o67452301));

      repeat (3) tick();
      areset_n = 1'b1;
      chk("rst_ready", 32'(bus.req_ready), 32'(1));
      chk("rst_valid", 32'(bus.cfg_valid), 32'(0));
      chk("rst_busy",  32'(busy),          32'(0));
      tick();

      // Identity
      run_txn(24'o76543210, 0, 1'b0, s, v, ci_s, co_s);
      chk("id_start_cyc", 32'(s), 32'(2));
      chk("id_valid_cyc", 32'(v), 32'(3 + L));
      chk("id_mn",  32'(col_mn), 32'(24'o76543210));
      chk("id_nb",  32'(col_nb), 32'(24'o67452301));
      chk("id_ci",  32'(bus.cfg_ci), 32'(ci_s));
      chk("id_co",  32'(bus.cfg_co), 32'(co_s));
      tick();

      // Reversal
      run_txn(24'o01234567, 1, 1'b0, s, v, ci_s, co_s);
      chk("rev_mn",  32'(col_mn),      32'(24'o01234567));
      chk("rev_nb",  32'(col_nb),      32'(24'o67452301));
      chk("rev_err", 32'(bus.cfg_err), 32'(0));
      chk("rev_ci",  32'(bus.cfg_ci),  32'(ci_s));

`ifdef BENES_CFG_CHECK_EN
      // Invalid: mp = {0,0,2,3,4,5,6,7}
      run_txn(24'o76543200, 0, 1'b0, s, v, ci_s, co_s);
      chk("inv_valid_cyc", 32'(v),           32'(2));
      chk("inv_start",     32'(s),           32'(-1));
      chk("inv_err",       32'(bus.cfg_err), 32'(1));
      chk("inv_ci",        32'(bus.cfg_ci),  32'(0));
      chk("inv_co",        32'(bus.cfg_co),  32'(0));
`endif

      // Backpressure, then a second request accepted in the very next cycle
      run_txn(rand_perm(), 5, 1'b0, s, v, ci_s, co_s);
      chk("bp_ci", 32'(bus.cfg_ci), 32'(ci_s));
      run_txn(rand_perm(), 0, 1'b0, s, v, ci_s, co_s);
      chk("b2b_valid_cyc", 32'(v), 32'(3 + L));

      // Busy ignore
      run_txn(24'o76543210, 0, 1'b1, s, v, ci_s, co_s);
      chk("ign_mp", 32'(col_mp), 32'(24'o76543210));

      // Reset in the middle of WAIT (accept + 5)
      bus.req_valid = 1'b1;
      bus.req_perm  = rand_perm();
      tick();
      bus.req_valid = 1'b0;
      s = cyc - 1;
      while (cyc < s + 5) tick();
      #1 areset_n = 1'b0;
      model_reset();
      #1;
      chk("mid_rst_valid", 32'(bus.cfg_valid), 32'(0));
      chk("mid_rst_ready", 32'(bus.req_ready), 32'(1));
      chk("mid_rst_busy",  32'(busy),          32'(0));
      chk("mid_rst_mp",    32'(col_mp),        32'(0));
      chk("mid_rst_start", 32'(col_start),     32'(0));
      repeat (2) tick();
      #1 areset_n = 1'b1;
      for (int k = 0; k < 15; k++) begin
         tick();
         chk("aborted_no_valid", 32'(bus.cfg_valid), 32'(0));
      end

      // Randomized traffic
      for (int t = 0; t < 60; t++) begin
         p = rand_perm();
         if (CHECK_EN && $urandom_range(4, 0) == 0) begin
            int a = int'($urandom_range(7, 0));
            int b = (a + 1 + int'($urandom_range(6, 0))) % 8;
            p[3*b +: 3] = p[3*a +: 3];
         end
         repeat ($urandom_range(3, 0)) tick();
         run_txn(p, int'($urandom_range(4, 0)), 1'($urandom_range(1, 0)), s, v, ci_s, co_s);
         if (!(CHECK_EN && !is_bij(p))) chk("rnd_ci", 32'(bus.cfg_ci), 32'(ci_s));
      end

      repeat (3) tick();
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
